// File: rtl/hd_pkg.sv
// ----------------------------------------------------------------------------
// hd_pkg
// Shared definitions for the hyperdimensional encode/classify block:
//   - default sizing parameters used by hd_encode_classify and hd_class_mem
//   - the controller state enumeration
// No ports (package).
// ----------------------------------------------------------------------------
package hd_pkg;

    localparam int HD_N_SIZE      = 16;
    localparam int HD_M_SIZE      = 16;
    localparam int HD_DIM_WIDTH   = 16;
    localparam int HD_FTWIDTH     = 8;
    localparam int HD_CLASS_NUM   = 26;
    localparam int HD_CHUNKS      = 4;
    localparam int HD_SCORE_WIDTH = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCORE  = 2'd1,
        DECIDE = 2'd2
    } hdState_e;

endpackage

// File: rtl/hd_class_mem.sv
// ----------------------------------------------------------------------------
// hd_class_mem
// Class hypervector storage. Bytes arrive one at a time and are gathered into
// an M_SIZE-byte word; the word is committed to the array when its last byte
// arrives. Reads are synchronous with one cycle of latency. The array has no
// reset so its contents survive a block reset (they are reloaded anyway).
// Ports:
//   clk       in   clock, rising edge
//   i_wrEn    in   byte write strobe (already qualified by the caller)
//   i_wrData  in   class byte
//   i_wrElem  in   element position of the byte inside its word
//   i_wrWord  in   word address being filled
//   i_rdAddr  in   read word address
//   o_rdData  out  registered read word, element m at [m*FTWIDTH +: FTWIDTH]
// ----------------------------------------------------------------------------
module hd_class_mem
    import hd_pkg::*;
#(
    parameter int M_SIZE  = HD_M_SIZE,
    parameter int FTWIDTH = HD_FTWIDTH,
    parameter int DEPTH   = HD_CLASS_NUM * HD_CHUNKS,
    parameter int EW      = (M_SIZE > 1) ? $clog2(M_SIZE) : 1,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      i_wrEn,
    input  logic [FTWIDTH-1:0]        i_wrData,
    input  logic [EW-1:0]             i_wrElem,
    input  logic [AW-1:0]             i_wrWord,
    input  logic [AW-1:0]             i_rdAddr,
    output logic [M_SIZE*FTWIDTH-1:0] o_rdData
);

    logic [M_SIZE*FTWIDTH-1:0] r_mem [DEPTH];
    logic [M_SIZE*FTWIDTH-1:0] r_assembly;
    logic [M_SIZE*FTWIDTH-1:0] r_rdData;
    logic [M_SIZE*FTWIDTH-1:0] w_wordIn;
    logic                      w_lastByte;

    // Current partial word with the incoming byte merged in, so the final
    // byte can be committed together with the ones gathered before it.
    always_comb begin
        w_wordIn = r_assembly;
        w_wordIn[i_wrElem*FTWIDTH +: FTWIDTH] = i_wrData;
        w_lastByte = (i_wrElem == EW'(M_SIZE - 1));
    end

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_assembly <= w_wordIn;
            if (w_lastByte) begin
                r_mem[i_wrWord] <= w_wordIn;
            end
        end
        r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/hd_encode_classify.sv
// ----------------------------------------------------------------------------
// hd_encode_classify
// Random-projection hypervector encoder followed by a dot-product classifier.
// Each accepted beat adds +/-feature sums into M_SIZE accumulators; when a
// chunk completes, the chunk is scored against every class (one class per
// cycle) and, after the last chunk, the best-scoring class is reported.
// Ports:
//   clk               in   sole clock, rising edge
//   reset             in   asynchronous, active-low
//   class_write       in   class byte strobe
//   class_in          in   signed class element
//   class_write_done  out  class memory fully loaded (sticky)
//   enc_valid         in   encoding beat valid
//   enc_last          in   last beat of the current chunk
//   projections       in   projection bit word (N_SIZE+M_SIZE bits)
//   features          in   N_SIZE unsigned features, n at [n*FTWIDTH +: FTWIDTH]
//   out               out  M_SIZE chunk accumulators, m at [m*DIM_WIDTH +: DIM_WIDTH]
//   done              out  one-cycle chunk-complete pulse
//   busy              out  scoring or deciding
//   class_out         out  winning class index (held)
//   class_valid       out  one-cycle result pulse
// ----------------------------------------------------------------------------
module hd_encode_classify
    import hd_pkg::*;
#(
    parameter int N_SIZE      = HD_N_SIZE,
    parameter int M_SIZE      = HD_M_SIZE,
    parameter int DIM_WIDTH   = HD_DIM_WIDTH,
    parameter int FTWIDTH     = HD_FTWIDTH,
    parameter int CLASS_NUM   = HD_CLASS_NUM,
    parameter int CHUNKS      = HD_CHUNKS,
    parameter int SCORE_WIDTH = HD_SCORE_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          class_write,
    input  logic [FTWIDTH-1:0]            class_in,
    output logic                          class_write_done,
    input  logic                          enc_valid,
    input  logic                          enc_last,
    input  logic [N_SIZE+M_SIZE-1:0]      projections,
    input  logic [N_SIZE*FTWIDTH-1:0]     features,
    output logic [M_SIZE*DIM_WIDTH-1:0]   out,
    output logic                          done,
    output logic                          busy,
    output logic [4:0]                    class_out,
    output logic                          class_valid
);

    localparam int DEPTH = CLASS_NUM * CHUNKS;
    localparam int PW    = N_SIZE + M_SIZE;
    localparam int EW    = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(CLASS_NUM + 1);
    localparam int KW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    hdState_e r_state;
    hdState_e w_nextState;

    logic [EW-1:0]                   r_wrElem;
    logic [AW-1:0]                   r_wrWord;
    logic                            r_classWriteDone;
    logic [DIM_WIDTH-1:0]            r_out [M_SIZE];
    logic signed [SCORE_WIDTH-1:0]   r_score [CLASS_NUM];
    logic [CW-1:0]                   r_scoreCnt;
    logic [KW-1:0]                   r_chunk;
    logic                            r_done;
    logic [4:0]                      r_classOut;
    logic                            r_classValid;

    logic                            w_wrAccept;
    logic                            w_accept;
    logic                            w_busy;
    logic                            w_scoreAcc;
    logic                            w_scoreExit;
    logic                            w_decide;
    logic [AW-1:0]                   w_rdAddr;
    logic [M_SIZE*FTWIDTH-1:0]       w_rdData;
    logic [DIM_WIDTH-1:0]            w_encSum [M_SIZE];
    logic signed [SCORE_WIDTH-1:0]   w_dot;
    logic signed [SCORE_WIDTH-1:0]   w_best;
    logic [4:0]                      w_argIdx;

    assign w_wrAccept = class_write && !r_classWriteDone;
    assign w_accept   = enc_valid && r_classWriteDone && !w_busy;

    // The read address runs one class ahead of the score update because the
    // memory read takes a cycle; the extra SCORE cycle drains the last class.
    assign w_rdAddr = (r_scoreCnt < CW'(CLASS_NUM))
                    ? AW'(r_scoreCnt) * AW'(CHUNKS) + AW'(r_chunk)
                    : '0;

    hd_class_mem #(
        .M_SIZE  (M_SIZE),
        .FTWIDTH (FTWIDTH),
        .DEPTH   (DEPTH),
        .EW      (EW),
        .AW      (AW)
    ) u_classMem (
        .clk      (clk),
        .i_wrEn   (w_wrAccept),
        .i_wrData (class_in),
        .i_wrElem (r_wrElem),
        .i_wrWord (r_wrWord),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    // Projection bit (m+n) mod PW selects whether feature n is added to or
    // subtracted from accumulator m; the result wraps at DIM_WIDTH bits.
    always_comb begin
        for (int m = 0; m < M_SIZE; m++) begin
            w_encSum[m] = '0;
            for (int n = 0; n < N_SIZE; n++) begin
                if (projections[(m + n) % PW]) begin
                    w_encSum[m] = w_encSum[m] + DIM_WIDTH'(features[n*FTWIDTH +: FTWIDTH]);
                end else begin
                    w_encSum[m] = w_encSum[m] - DIM_WIDTH'(features[n*FTWIDTH +: FTWIDTH]);
                end
            end
        end
    end

    // Signed dot product of the chunk accumulators with the class word that
    // the memory is presenting this cycle.
    always_comb begin
        w_dot = '0;
        for (int m = 0; m < M_SIZE; m++) begin
            w_dot = w_dot + SCORE_WIDTH'($signed(r_out[m]))
                          * SCORE_WIDTH'($signed(w_rdData[m*FTWIDTH +: FTWIDTH]));
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best   = r_score[0];
        w_argIdx = '0;
        for (int k = 1; k < CLASS_NUM; k++) begin
            if (r_score[k] > w_best) begin
                w_best   = r_score[k];
                w_argIdx = 5'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (r_done) begin
                    w_nextState = SCORE;
                end
            end
            SCORE: begin
                if (r_scoreCnt == CW'(CLASS_NUM)) begin
                    w_nextState = (r_chunk == KW'(CHUNKS - 1)) ? DECIDE : IDLE;
                end
            end
            DECIDE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State-decoded controls.
    always_comb begin
        w_busy      = (r_state == SCORE) || (r_state == DECIDE);
        w_scoreAcc  = (r_state == SCORE) && (r_scoreCnt != '0);
        w_scoreExit = (r_state == SCORE) && (r_scoreCnt == CW'(CLASS_NUM));
        w_decide    = (r_state == DECIDE);
    end

    // Class memory write pointer; the done flag is sticky and blocks further
    // writes until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrElem         <= '0;
            r_wrWord         <= '0;
            r_classWriteDone <= 1'b0;
        end else if (w_wrAccept) begin
            if (r_wrElem == EW'(M_SIZE - 1)) begin
                r_wrElem <= '0;
                if (r_wrWord == AW'(DEPTH - 1)) begin
                    r_classWriteDone <= 1'b1;
                end else begin
                    r_wrWord <= r_wrWord + 1'b1;
                end
            end else begin
                r_wrElem <= r_wrElem + 1'b1;
            end
        end
    end

    // Chunk accumulators and the chunk-complete pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < M_SIZE; m++) begin
                r_out[m] <= '0;
            end
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept && enc_last;
            for (int m = 0; m < M_SIZE; m++) begin
                if (w_scoreExit) begin
                    r_out[m] <= '0;
                end else if (w_accept) begin
                    r_out[m] <= r_out[m] + w_encSum[m];
                end
            end
        end
    end

    // Scoring sequencer, per-class scores, chunk index and the final result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scoreCnt   <= '0;
            r_chunk      <= '0;
            r_classOut   <= '0;
            r_classValid <= 1'b0;
            for (int k = 0; k < CLASS_NUM; k++) begin
                r_score[k] <= '0;
            end
        end else begin
            r_classValid <= w_decide;
            if (r_state == SCORE && !w_scoreExit) begin
                r_scoreCnt <= r_scoreCnt + 1'b1;
            end else begin
                r_scoreCnt <= '0;
            end
            if (w_scoreExit && r_chunk != KW'(CHUNKS - 1)) begin
                r_chunk <= r_chunk + 1'b1;
            end else if (w_decide) begin
                r_chunk <= '0;
            end
            if (w_decide) begin
                r_classOut <= w_argIdx;
            end
            for (int k = 0; k < CLASS_NUM; k++) begin
                if (w_decide) begin
                    r_score[k] <= '0;
                end else if (w_scoreAcc && r_scoreCnt == CW'(k + 1)) begin
                    r_score[k] <= r_score[k] + w_dot;
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < M_SIZE; m++) begin
            out[m*DIM_WIDTH +: DIM_WIDTH] = r_out[m];
        end
    end

    assign class_write_done = r_classWriteDone;
    assign done             = r_done;
    assign busy             = w_busy;
    assign class_out        = r_classOut;
    assign class_valid      = r_classValid;

endmodule

// File: tb/tb_hd_encode_classify.sv
// ----------------------------------------------------------------------------
// tb_hd_encode_classify
// Directed bench for hd_encode_classify at default sizes. Expected chunk
// accumulators and class results are queued by the stimulus side and popped
// by an independent monitor whenever done or class_valid appears.
// ----------------------------------------------------------------------------
module tb_hd_encode_classify;

    localparam int NB  = 16;
    localparam int MB  = 16;
    localparam int DW  = 16;
    localparam int FW  = 8;
    localparam int TOT = 1664;
    localparam int BPC = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            class_write = 1'b0;
    logic [FW-1:0]   class_in = '0;
    logic            class_write_done;
    logic            enc_valid = 1'b0;
    logic            enc_last = 1'b0;
    logic [31:0]     projections = '0;
    logic [NB*FW-1:0] features = '0;
    logic [MB*DW-1:0] out;
    logic            done;
    logic            busy;
    logic [4:0]      class_out;
    logic            class_valid;

    int errCount   = 0;
    int checkCount = 0;

    logic [255:0] expOutQ [$];
    logic [4:0]   expClassQ [$];
    logic [255:0] monOut;
    logic [4:0]   monClass;

    logic [127:0] featOnes;
    logic [127:0] featTwos;
    logic [127:0] featRamp;
    logic [255:0] expMixed;

    hd_encode_classify dut (
        .clk              (clk),
        .reset            (reset),
        .class_write      (class_write),
        .class_in         (class_in),
        .class_write_done (class_write_done),
        .enc_valid        (enc_valid),
        .enc_last         (enc_last),
        .projections      (projections),
        .features         (features),
        .out              (out),
        .done             (done),
        .busy             (busy),
        .class_out        (class_out),
        .class_valid      (class_valid)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run still active at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any done or class_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                if (expOutQ.size() == 0) begin
                    checkCount++;
                    errCount++;
                    $display("[TB] FAIL unexpected_done: got done=1 with out=%0h expected no done", out);
                end else begin
                    monOut = expOutQ.pop_front();
                    checkOutput("chunk_out", 256'(out), monOut);
                end
            end
            if (class_valid) begin
                if (expClassQ.size() == 0) begin
                    checkCount++;
                    errCount++;
                    $display("[TB] FAIL unexpected_class_valid: got class_out=%0d expected no result", class_out);
                end else begin
                    monClass = expClassQ.pop_front();
                    checkOutput("class_out", 256'(class_out), 256'(monClass));
                end
            end
        end
    end

    // One encoding beat held for exactly one cycle.
    task automatic applyStimulus(input logic [31:0] proj, input logic [127:0] feat, input logic last);
        @(negedge clk);
        projections = proj;
        features    = feat;
        enc_last    = last;
        enc_valid   = 1'b1;
        @(negedge clk);
        enc_valid   = 1'b0;
        enc_last    = 1'b0;
    endtask

    // Counts busy cycles of one scoring pass; optionally offers a beat while
    // busy, which must be dropped.
    task automatic waitIdle(input int expBusy, input bit poke);
        int c;
        c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                c++;
                enc_valid = poke && (c == 5);
                enc_last  = poke && (c == 5);
            end else if (c > 0) begin
                break;
            end
        end
        enc_valid = 1'b0;
        enc_last  = 1'b0;
        checkOutput("busy_cycles", 256'(c), 256'(expBusy));
    endtask

    task automatic runChunk(input logic [31:0] proj, input logic [127:0] feat,
                            input logic [15:0] expVal, input bit lastChunk, input bit poke);
        expOutQ.push_back({16{expVal}});
        applyStimulus(proj, feat, 1'b1);
        waitIdle(lastChunk ? 28 : 27, poke);
    endtask

    // Class 5 gets +1 everywhere, every other class 0.
    task automatic loadClasses(input bit extra);
        for (int a = 0; a < TOT; a++) begin
            @(negedge clk);
            if (a == TOT - 1) begin
                checkOutput("write_done_before_last", 256'(class_write_done), 256'(0));
            end
            class_write = 1'b1;
            class_in    = (a / BPC == 5) ? 8'd1 : 8'd0;
        end
        @(negedge clk);
        class_write = 1'b0;
        checkOutput("write_done_after_last", 256'(class_write_done), 256'(1));
        if (extra) begin
            class_write = 1'b1;
            class_in    = 8'd127;
            @(negedge clk);
            class_write = 1'b0;
        end
    endtask

    initial begin
        for (int n = 0; n < NB; n++) begin
            featOnes[n*8 +: 8] = 8'd1;
            featTwos[n*8 +: 8] = 8'd2;
            featRamp[n*8 +: 8] = 8'(n);
        end
        // Ramp features with low-half projections, then all-minus twos.
        for (int m = 0; m < MB; m++) begin
            expMixed[m*16 +: 16] = 16'((16 - m) * (15 - m) - 120 - 32);
        end

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_done", 256'(done), 256'(0));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_class_valid", 256'(class_valid), 256'(0));
        checkOutput("reset_class_out", 256'(class_out), 256'(0));
        checkOutput("reset_write_done", 256'(class_write_done), 256'(0));
        checkOutput("reset_out", 256'(out), 256'(0));

        // Beats before the class memory is loaded are dropped.
        applyStimulus(32'hFFFF_FFFF, featOnes, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("preload_out", 256'(out), 256'(0));
        checkOutput("preload_busy", 256'(busy), 256'(0));

        loadClasses(1'b1);

        // Query 1: four +16 chunks, class 5 scores 1024.
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b0, 1'b0);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b0, 1'b1);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b0, 1'b0);
        expClassQ.push_back(5'd5);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("post_query_out", 256'(out), 256'(0));

        // Query 2: negative class-5 score, all others zero -> index 0.
        expOutQ.push_back(expMixed);
        applyStimulus(32'h0000_FFFF, featRamp, 1'b0);
        applyStimulus(32'h0000_0000, featTwos, 1'b1);
        waitIdle(27, 1'b0);
        checkOutput("class_out_held", 256'(class_out), 256'(5));
        runChunk(32'h0000_0000, featTwos, 16'hFFE0, 1'b0, 1'b0);
        runChunk(32'h0000_0000, featTwos, 16'hFFE0, 1'b0, 1'b0);
        expClassQ.push_back(5'd0);
        runChunk(32'h0000_0000, featTwos, 16'hFFE0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in the middle of scoring aborts the query.
        expOutQ.push_back({16{16'd16}});
        applyStimulus(32'hFFFF_FFFF, featOnes, 1'b1);
        begin
            int c;
            c = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy) c++;
                if (c == 10) break;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 256'(busy), 256'(0));
        checkOutput("abort_write_done", 256'(class_write_done), 256'(0));
        checkOutput("abort_out", 256'(out), 256'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reload and run a full query from chunk 0: -512 + 3*256 = 256 for class 5.
        loadClasses(1'b0);
        runChunk(32'h0000_0000, featTwos, 16'hFFE0, 1'b0, 1'b0);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b0, 1'b0);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b0, 1'b0);
        expClassQ.push_back(5'd5);
        runChunk(32'hFFFF_FFFF, featOnes, 16'd16, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        checkOutput("out_queue_drained", 256'(expOutQ.size()), 256'(0));
        checkOutput("class_queue_drained", 256'(expClassQ.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
